// File: rtl/riscv_core_dcache_pkg.sv
// Shared types and helpers for the L1 data cache data array: access sizes,
// data-array FSM states, address-field geometry and load/store byte lanes.
package riscv_core_dcache_pkg;

  localparam int DWORD_BITS    = 64;
  localparam int DWORD_BYTES   = 8;
  localparam int BYTE_SEL_BITS = 3;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_EVICT_LOAD,
    ST_EVICT
  } state_e;

  function automatic int index_lsb(input int block_offset);
    return block_offset + BYTE_SEL_BITS;
  endfunction

  function automatic int index_msb(input int index_width, input int block_offset);
    return index_width + block_offset + BYTE_SEL_BITS - 1;
  endfunction

  function automatic int calc_beats(input int block_offset, input int axi_width);
    return (DWORD_BITS << block_offset) / axi_width;
  endfunction

  // Width of a select/counter for n items; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] size_mask(input size_e s);
    case (s)
      SIZE_BYTE: return 8'h01;
      SIZE_HALF: return 8'h03;
      SIZE_WORD: return 8'h0F;
      default:   return 8'hFF;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] off, input size_e s);
    case (s)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~off[0];
      SIZE_WORD: return (off[1:0] == 2'b00);
      default:   return (off == 3'b000);
    endcase
  endfunction

  function automatic logic [63:0] align_load(input logic [63:0] dw, input logic [2:0] off,
                                             input size_e s);
    logic [63:0] sh;
    sh = dw >> {off, 3'b000};
    case (s)
      SIZE_BYTE: return {56'd0, sh[7:0]};
      SIZE_HALF: return {48'd0, sh[15:0]};
      SIZE_WORD: return {32'd0, sh[31:0]};
      default:   return sh;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_dcache_way_bank.sv
// Storage for one cache way: byte-masked line write, registered dword read
// for core loads and a combinational full-line read for eviction.
module riscv_core_dcache_way_bank
  import riscv_core_dcache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 7,
  parameter int BLOCK_OFFSET = 2,
  localparam int SETS        = 2 ** INDEX_WIDTH,
  localparam int LINE_BITS   = DWORD_BITS << BLOCK_OFFSET,
  localparam int LINE_BYTES  = LINE_BITS / 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    wr_en,
  input  logic [INDEX_WIDTH-1:0]  wr_index,
  input  logic [LINE_BYTES-1:0]   wr_mask,
  input  logic [LINE_BITS-1:0]    wr_data,
  input  logic                    rd_en,
  input  logic [INDEX_WIDTH-1:0]  rd_index,
  input  logic [BLOCK_OFFSET-1:0] rd_dword,
  output logic [DWORD_BITS-1:0]   rd_data,
  input  logic [INDEX_WIDTH-1:0]  line_index,
  output logic [LINE_BITS-1:0]    line_data
);

  logic [LINE_BITS-1:0] mem [SETS];

  // Contents survive reset on purpose; validity lives in the tag store.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (wr_mask[b]) begin
          mem[wr_index][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_index][int'(rd_dword)*DWORD_BITS +: DWORD_BITS];
    end
  end

  assign line_data = mem[line_index];

endmodule

// File: rtl/riscv_core_dcache_data_array.sv
// L1 data cache data array: core byte-granular loads/stores plus AXI-side
// multi-beat line refill and dirty-line eviction with valid/ready handshakes.
module riscv_core_dcache_data_array
  import riscv_core_dcache_pkg::*;
#(
  parameter int WAYS            = 2,
  parameter int INDEX_WIDTH     = 7,
  parameter int BLOCK_OFFSET    = 2,
  parameter int CORE_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 64,
  parameter int AXI_DATA_WIDTH  = 64,
  localparam int WAY_W          = cnt_width(WAYS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [ADDR_WIDTH-1:0]      i_addr,
  input  logic [WAY_W-1:0]           i_way,
  input  logic [CORE_DATA_WIDTH-1:0] i_wdata,
  input  logic [1:0]                 i_size,
  input  logic                       i_rd_en,
  input  logic                       i_wr_en,
  output logic [CORE_DATA_WIDTH-1:0] o_rdata,
  output logic                       o_rd_valid,
  output logic                       o_misaligned,
  output logic                       o_busy,
  input  logic                       i_refill_start,
  input  logic                       i_refill_valid,
  input  logic [AXI_DATA_WIDTH-1:0]  i_refill_data,
  output logic                       o_refill_ready,
  output logic                       o_refill_done,
  input  logic                       i_evict_start,
  output logic                       o_evict_valid,
  output logic [AXI_DATA_WIDTH-1:0]  o_evict_data,
  output logic                       o_evict_last,
  input  logic                       i_evict_ready
);

  localparam int LINE_BITS  = DWORD_BITS << BLOCK_OFFSET;
  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam int DWORDS     = 1 << BLOCK_OFFSET;
  localparam int BEATS      = calc_beats(BLOCK_OFFSET, AXI_DATA_WIDTH);
  localparam int BEAT_W     = cnt_width(BEATS);
  localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
  localparam int IDX_LSB    = index_lsb(BLOCK_OFFSET);
  localparam int IDX_MSB    = index_msb(INDEX_WIDTH, BLOCK_OFFSET);

  state_e                  state, state_next;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [INDEX_WIDTH-1:0]  lat_index;
  logic [WAY_W-1:0]        lat_way;
  logic [LINE_BITS-1:0]    line_buf;
  logic                    refill_done_q, rd_valid_q, misaligned_q;
  logic [WAY_W-1:0]        load_way_q;
  logic [2:0]              load_off_q;
  size_e                   load_size_q;

  logic [INDEX_WIDTH-1:0]  addr_index;
  logic [BLOCK_OFFSET-1:0] addr_dword;
  logic [2:0]              addr_byte;
  size_e                   size;
  logic                    unused_addr_bits;

  assign addr_index       = i_addr[IDX_MSB:IDX_LSB];
  assign addr_dword       = i_addr[IDX_LSB-1:BYTE_SEL_BITS];
  assign addr_byte        = i_addr[BYTE_SEL_BITS-1:0];
  assign size             = size_e'(i_size);
  assign unused_addr_bits = ^i_addr[ADDR_WIDTH-1:IDX_MSB+1];

  logic idle, access_ok, core_wr, core_rd, core_misaligned, refill_beat, last_beat;

  assign idle            = (state == ST_IDLE);
  assign access_ok       = is_aligned(addr_byte, size);
  assign core_wr         = idle && i_wr_en && access_ok;
  assign core_rd         = idle && i_rd_en && access_ok;
  assign core_misaligned = idle && (i_rd_en || i_wr_en) && !access_ok;
  assign refill_beat     = (state == ST_REFILL) && i_refill_valid;
  assign last_beat       = (beat_cnt == BEAT_W'(BEATS - 1));

  logic [7:0]            store_byte_en;
  logic [DWORD_BITS-1:0] store_dw;

  assign store_byte_en = size_mask(size) << addr_byte;
  assign store_dw      = i_wdata << {addr_byte, 3'b000};

  logic                   wr_any;
  logic [WAY_W-1:0]       wr_way;
  logic [INDEX_WIDTH-1:0] wr_index;
  logic [LINE_BYTES-1:0]  wr_mask;
  logic [LINE_BITS-1:0]   wr_data;

  // Core stores and refill beats share one line-wide masked write port; the
  // data is replicated across the line so only the mask needs positioning.
  always_comb begin
    wr_any   = 1'b0;
    wr_way   = i_way;
    wr_index = addr_index;
    wr_mask  = '0;
    wr_data  = '0;
    if (core_wr) begin
      wr_any  = 1'b1;
      wr_mask = LINE_BYTES'(store_byte_en) << (int'(addr_dword) * DWORD_BYTES);
      wr_data = {DWORDS{store_dw}};
    end else if (refill_beat) begin
      wr_any   = 1'b1;
      wr_way   = lat_way;
      wr_index = lat_index;
      wr_mask  = LINE_BYTES'({BEAT_BYTES{1'b1}}) << (int'(beat_cnt) * BEAT_BYTES);
      wr_data  = {BEATS{i_refill_data}};
    end
  end

  logic [DWORD_BITS-1:0] bank_rdata [WAYS];
  logic [LINE_BITS-1:0]  bank_line  [WAYS];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    riscv_core_dcache_way_bank #(
      .INDEX_WIDTH  (INDEX_WIDTH),
      .BLOCK_OFFSET (BLOCK_OFFSET)
    ) u_bank (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .wr_en      (wr_any && (wr_way == WAY_W'(w))),
      .wr_index   (wr_index),
      .wr_mask    (wr_mask),
      .wr_data    (wr_data),
      .rd_en      (core_rd && (i_way == WAY_W'(w))),
      .rd_index   (addr_index),
      .rd_dword   (addr_dword),
      .rd_data    (bank_rdata[w]),
      .line_index (lat_index),
      .line_data  (bank_line[w])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Eviction takes priority so a dirty victim leaves before its slot is refilled.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (i_evict_start)       state_next = ST_EVICT_LOAD;
        else if (i_refill_start) state_next = ST_REFILL;
      end
      ST_REFILL:     if (refill_beat && last_beat)   state_next = ST_IDLE;
      ST_EVICT_LOAD: state_next = ST_EVICT;
      ST_EVICT:      if (i_evict_ready && last_beat) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt      <= '0;
      lat_index     <= '0;
      lat_way       <= '0;
      line_buf      <= '0;
      refill_done_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      misaligned_q  <= 1'b0;
      load_way_q    <= '0;
      load_off_q    <= '0;
      load_size_q   <= SIZE_BYTE;
    end else begin
      rd_valid_q    <= core_rd;
      misaligned_q  <= core_misaligned;
      refill_done_q <= refill_beat && last_beat;
      if (core_rd) begin
        load_way_q  <= i_way;
        load_off_q  <= addr_byte;
        load_size_q <= size;
      end
      case (state)
        ST_IDLE: begin
          if (i_evict_start || i_refill_start) begin
            lat_index <= addr_index;
            lat_way   <= i_way;
            beat_cnt  <= '0;
          end
        end
        ST_REFILL: begin
          if (refill_beat) beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        end
        ST_EVICT_LOAD: line_buf <= bank_line[lat_way];
        ST_EVICT: begin
          if (i_evict_ready) beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_busy         = !idle;
  assign o_refill_ready = (state == ST_REFILL);
  assign o_refill_done  = refill_done_q;
  assign o_evict_valid  = (state == ST_EVICT);
  assign o_evict_data   = o_evict_valid ?
                          line_buf[int'(beat_cnt)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] : '0;
  assign o_evict_last   = o_evict_valid && last_beat;
  assign o_rd_valid     = rd_valid_q;
  assign o_misaligned   = misaligned_q;
  assign o_rdata        = align_load(bank_rdata[load_way_q], load_off_q, load_size_q);

endmodule

// File: tb/tb_riscv_core_dcache_data_array.sv
// Directed bench for the dcache data array: expected load results and evict
// beats are queued as stimulus is driven and checked as the DUT emits them.
module tb_riscv_core_dcache_data_array;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [63:0] i_addr = '0;
  logic        i_way = 1'b0;
  logic [63:0] i_wdata = '0;
  logic [1:0]  i_size = 2'b00;
  logic        i_rd_en = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [63:0] o_rdata;
  logic        o_rd_valid, o_misaligned, o_busy;
  logic        i_refill_start = 1'b0;
  logic        i_refill_valid = 1'b0;
  logic [63:0] i_refill_data = '0;
  logic        o_refill_ready, o_refill_done;
  logic        i_evict_start = 1'b0;
  logic        o_evict_valid;
  logic [63:0] o_evict_data;
  logic        o_evict_last;
  logic        i_evict_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [63:0] rd_exp_q[$];
  string       rd_tag_q[$];
  logic [64:0] ev_exp_q[$];
  logic [63:0] mon_exp;
  string       mon_tag;

  riscv_core_dcache_data_array dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_addr         (i_addr),
    .i_way          (i_way),
    .i_wdata        (i_wdata),
    .i_size         (i_size),
    .i_rd_en        (i_rd_en),
    .i_wr_en        (i_wr_en),
    .o_rdata        (o_rdata),
    .o_rd_valid     (o_rd_valid),
    .o_misaligned   (o_misaligned),
    .o_busy         (o_busy),
    .i_refill_start (i_refill_start),
    .i_refill_valid (i_refill_valid),
    .i_refill_data  (i_refill_data),
    .o_refill_ready (o_refill_ready),
    .o_refill_done  (o_refill_done),
    .i_evict_start  (i_evict_start),
    .o_evict_valid  (o_evict_valid),
    .o_evict_data   (o_evict_data),
    .o_evict_last   (o_evict_last),
    .i_evict_ready  (i_evict_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_store(input logic [63:0] addr, input logic way, input logic [1:0] size,
                             input logic [63:0] data);
    i_addr = addr; i_way = way; i_size = size; i_wdata = data; i_wr_en = 1'b1;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic apply_load(input logic [63:0] addr, input logic way, input logic [1:0] size,
                            input logic [63:0] exp, input string tag);
    i_addr = addr; i_way = way; i_size = size; i_rd_en = 1'b1;
    rd_exp_q.push_back(exp);
    rd_tag_q.push_back(tag);
    tick();
    i_rd_en = 1'b0;
  endtask

  task automatic push_evict_line(input logic [63:0] base);
    for (int k = 0; k < 4; k++) ev_exp_q.push_back({(k == 3), base + 64'(k)});
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 20 && o_busy; n++) tick();
    check_output(tag, 64'(o_busy), 64'd0);
  endtask

  // Scoreboard side: loads and evict beats are checked where the DUT presents them.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_rd_valid) begin
        if (rd_exp_q.size() == 0) begin
          check_output("rd_unexpected", 64'(o_rd_valid), 64'd0);
        end else begin
          mon_exp = rd_exp_q.pop_front();
          mon_tag = rd_tag_q.pop_front();
          check_output(mon_tag, o_rdata, mon_exp);
        end
      end
      if (o_evict_valid) begin
        if (ev_exp_q.size() == 0) begin
          check_output("evict_unexpected", 64'(o_evict_valid), 64'd0);
        end else begin
          check_output("evict_data", o_evict_data, ev_exp_q[0][63:0]);
          check_output("evict_last", 64'(o_evict_last), 64'(ev_exp_q[0][64]));
          if (i_evict_ready) void'(ev_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) tick();
    check_output("reset_flags",
                 64'({o_rd_valid, o_misaligned, o_busy, o_refill_ready, o_refill_done,
                      o_evict_valid, o_evict_last}), 64'd0);
    check_output("reset_rdata", o_rdata, 64'd0);
    check_output("reset_evict_data", o_evict_data, 64'd0);
    i_rst_n = 1'b1;
    tick();

    // Core stores/loads, sub-dword lanes and write+read in the same cycle.
    apply_store(64'h1008, 1'b0, 2'b11, 64'hDEADBEEF_CAFEF00D);
    apply_store(64'h1008, 1'b1, 2'b11, 64'h11223344_55667788);
    apply_load (64'h1008, 1'b1, 2'b11, 64'h11223344_55667788, "ld_way1");
    apply_load (64'h1008, 1'b0, 2'b11, 64'hDEADBEEF_CAFEF00D, "ld_way0");
    apply_store(64'h100B, 1'b1, 2'b00, 64'h0000_0000_0000_00AB);
    apply_load (64'h100A, 1'b1, 2'b01, 64'h0000_0000_0000_AB66, "lh_100a");
    apply_load (64'h1008, 1'b1, 2'b10, 64'h0000_0000_AB66_7788, "lw_1008");
    apply_load (64'h100F, 1'b1, 2'b00, 64'h0000_0000_0000_0011, "lb_100f");

    i_addr = 64'h1002; i_way = 1'b1; i_size = 2'b10; i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    check_output("misaligned_ld", 64'(o_misaligned), 64'd1);
    check_output("misaligned_ld_valid", 64'(o_rd_valid), 64'd0);
    apply_store(64'h1009, 1'b1, 2'b01, 64'h0000_0000_0000_FFFF);
    check_output("misaligned_sh", 64'(o_misaligned), 64'd1);
    apply_load (64'h1008, 1'b1, 2'b11, 64'h11223344_AB667788, "ld_after_bad_sh");
    check_output("misaligned_pulse_end", 64'(o_misaligned), 64'd0);

    i_addr = 64'h1008; i_way = 1'b1; i_size = 2'b11; i_wdata = 64'h01020304_05060708;
    i_rd_en = 1'b1; i_wr_en = 1'b1;
    rd_exp_q.push_back(64'h11223344_AB667788);
    rd_tag_q.push_back("rw_same_cycle_old");
    tick();
    i_rd_en = 1'b0; i_wr_en = 1'b0;
    apply_load (64'h1008, 1'b1, 2'b11, 64'h01020304_05060708, "rw_same_cycle_new");

    // Refill index 5 way 0 with gaps between beats.
    i_addr = 64'hA0; i_way = 1'b0; i_refill_start = 1'b1;
    tick();
    i_refill_start = 1'b0;
    check_output("refill_busy", 64'(o_busy), 64'd1);
    check_output("refill_ready", 64'(o_refill_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      if (k == 1 || k == 3) begin
        i_refill_valid = 1'b0;
        tick();
      end
      i_refill_valid = 1'b1;
      i_refill_data  = 64'hA0 + 64'(k);
      tick();
      if (k == 2) check_output("refill_done_early", 64'(o_refill_done), 64'd0);
    end
    i_refill_valid = 1'b0;
    check_output("refill_done", 64'(o_refill_done), 64'd1);
    check_output("refill_idle", 64'(o_busy), 64'd0);
    tick();
    check_output("refill_done_pulse", 64'(o_refill_done), 64'd0);
    apply_load (64'hB0, 1'b0, 2'b11, 64'hA2, "refill_ld_dw2");
    apply_load (64'hA0, 1'b0, 2'b11, 64'hA0, "refill_ld_dw0");
    apply_load (64'hB8, 1'b0, 2'b10, 64'hA3, "refill_lw_dw3");

    // Evict the same line with a three-cycle stall on beat 1.
    i_addr = 64'hA0; i_way = 1'b0; i_evict_start = 1'b1;
    tick();
    i_evict_start = 1'b0;
    check_output("evict_busy", 64'(o_busy), 64'd1);
    check_output("evict_valid_early", 64'(o_evict_valid), 64'd0);
    push_evict_line(64'hA0);
    i_evict_ready = 1'b1;
    tick();
    check_output("evict_valid_2cyc", 64'(o_evict_valid), 64'd1);
    tick();
    i_evict_ready = 1'b0;
    repeat (3) tick();
    i_evict_ready = 1'b1;
    wait_idle("evict_finish");
    check_output("evict_all_beats", 64'(ev_exp_q.size()), 64'd0);

    // Simultaneous starts: evict wins; a load in that cycle is still served.
    i_addr = 64'hB0; i_way = 1'b0; i_size = 2'b11;
    i_evict_start = 1'b1; i_refill_start = 1'b1; i_rd_en = 1'b1;
    rd_exp_q.push_back(64'hA2);
    rd_tag_q.push_back("ld_with_start");
    push_evict_line(64'hA0);
    tick();
    i_evict_start = 1'b0; i_refill_start = 1'b0; i_rd_en = 1'b0;
    check_output("evict_wins_ready", 64'(o_refill_ready), 64'd0);
    check_output("evict_wins_busy", 64'(o_busy), 64'd1);
    wait_idle("evict2_finish");
    check_output("evict2_all_beats", 64'(ev_exp_q.size()), 64'd0);
    check_output("refill_not_taken", 64'(o_refill_ready), 64'd0);

    // Reset in the middle of a refill.
    i_evict_ready = 1'b0;
    i_addr = 64'hC0; i_way = 1'b1; i_refill_start = 1'b1;
    tick();
    i_refill_start = 1'b0;
    i_refill_valid = 1'b1; i_refill_data = 64'h55;
    repeat (2) tick();
    i_refill_valid = 1'b0;
    check_output("midrefill_busy", 64'(o_busy), 64'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check_output("rst_async_busy", 64'(o_busy), 64'd0);
    check_output("rst_async_ready", 64'(o_refill_ready), 64'd0);
    tick();
    check_output("rst_edge_busy", 64'(o_busy), 64'd0);
    i_rst_n = 1'b1;
    tick();
    apply_load (64'h1008, 1'b1, 2'b11, 64'h01020304_05060708, "keep_after_rst_w1");
    apply_load (64'hB0, 1'b0, 2'b11, 64'hA2, "keep_after_rst_w0");

    // A fresh refill after reset must start from beat 0.
    i_addr = 64'hC0; i_way = 1'b1; i_refill_start = 1'b1;
    tick();
    i_refill_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_refill_valid = 1'b1;
      i_refill_data  = 64'hC0 + 64'(k);
      tick();
    end
    i_refill_valid = 1'b0;
    check_output("refill2_done", 64'(o_refill_done), 64'd1);
    apply_load (64'hC0, 1'b1, 2'b11, 64'hC0, "refill2_dw0");
    apply_load (64'hD8, 1'b1, 2'b11, 64'hC3, "refill2_dw3");

    repeat (2) tick();
    check_output("rd_queue_drained", 64'(rd_exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
